// File: rtl/y86_pkg.sv
// Shared Y86 definitions: word width, instruction codes, data-memory responder states.
// No logic; constants and types only.
package y86_pkg;

    localparam int WORD_W = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/y86_byte_ram.sv
// Byte-wide single-port storage: synchronous write, asynchronous read.
// Latency: read combinational, write lands on the next rising edge; no backpressure.
// Contents are never reset.
module y86_byte_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/y86_dmem_responder.sv
// Y86 data-memory responder: 64-bit little-endian load/store over a byte RAM, one byte per cycle.
// Latency: response valid 9 cycles after request handshake (1 cycle for errors); one access in flight.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready. Option: DMEM_ALIGN_CHECK_EN.
module y86_dmem_responder
    import y86_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    dmem_state_e       state_q, state_d;
    logic [2:0]        cnt_q;
    logic              write_q;
    logic [AW-1:0]     addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata_q;
    logic              error_q;

    logic              req_bad;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    // A single unsigned compare also catches addr+7 overflow: nothing above DEPTH-8 is legal.
`ifdef DMEM_ALIGN_CHECK_EN
    assign req_bad = (req_addr > 64'(DEPTH - 8)) || (req_addr[2:0] != 3'b000);
`else
    assign req_bad = (req_addr > 64'(DEPTH - 8));
`endif

    assign ram_addr  = addr_q + AW'(cnt_q);
    assign ram_wdata = wdata_q[{cnt_q, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_bad ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_we = write_q;
                if (cnt_q == 3'd7) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid) begin
                write_q <= req_write;
                addr_q  <= req_addr[AW-1:0];
                wdata_q <= req_wdata;
                cnt_q   <= 3'd0;
                rdata_q <= '0;
                error_q <= req_bad;
            end else if (state_q == S_ACCESS) begin
                if (!write_q) begin
                    rdata_q[{cnt_q, 3'b000} +: 8] <= ram_rdata;
                end
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

    y86_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Directed bench for y86_dmem_responder against a byte-array memory model with per-cycle output checks.
module tb_y86_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_error;

    always #5 clk = ~clk;

    y86_dmem_responder #(.DEPTH(1024), .AW(10)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Model state: memory image plus the response currently owed.
    logic [7:0]  mm [0:1023];
    logic        pending = 1'b0;
    logic        busy = 1'b0;
    logic [63:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    int          exp_first = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    function automatic logic model_err(input logic [63:0] a);
        logic e;
        e = (a > 64'd1016);
`ifdef DMEM_ALIGN_CHECK_EN
        e = e || (a[2:0] != 3'b000);
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
            check("reset req_ready", {63'd0, req_ready}, 64'd1);
            check("reset rsp_rdata", rsp_rdata, 64'd0);
            check("reset rsp_error", {63'd0, rsp_error}, 64'd0);
        end else begin
            check("req_ready", {63'd0, req_ready}, {63'd0, !busy});
            if (pending && cycle >= exp_first) begin
                check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_error", {63'd0, rsp_error}, {63'd0, exp_err});
            end else begin
                check("rsp_valid idle", {63'd0, rsp_valid}, 64'd0);
            end
        end
    end

    // One complete transaction; lat is response-valid cycle minus handshake edge (T+lat+1).
    task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input int hold, input logic pre,
                        output logic [63:0] got_rdata, output logic got_err, output int lat);
        logic        e;
        logic [63:0] r;
        int          hs;
        int          seen;
        e = model_err(a);
        r = '0;
        if (!e && !w) begin
            for (int i = 0; i < 8; i++) r[8*i +: 8] = mm[int'(a[9:0]) + i];
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = pre;
        @(posedge clk); #1;
        req_valid = 1'b0;
        hs = cycle;
        exp_rdata = r; exp_err = e; exp_first = hs + (e ? 0 : 8);
        pending = 1'b1; busy = 1'b1;
        if (w && !e) begin
            for (int i = 0; i < 8; i++) mm[int'(a[9:0]) + i] = d[8*i +: 8];
        end
        seen = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = cycle;
                break;
            end
        end
        checks++;
        if (seen < 0) begin
            errors++;
            $display("FAIL rsp timeout: no rsp_valid within 20 cycles of request @%h", a);
            seen = hs;
        end
        lat = seen - hs;
        got_rdata = rsp_rdata;
        got_err = rsp_error;
        if (!pre) begin
            repeat (hold) @(negedge clk);
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        pending = 1'b0; busy = 1'b0; rsp_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        xact(1'b1, 64'h0, 64'h0706050403020100, 0, 1'b0, rd, er, lat);

        // Store/load round trip.
        xact(1'b1, 64'h10, 64'h1122334455667788, 0, 1'b0, rd, er, lat);
        check("store latency T+", 64'(lat + 1), 64'd9);
        check("store rdata", rd, 64'd0);
        check("ram byte 0x10", {56'd0, u_dut.u_ram.mem[16]}, 64'h88);
        check("ram byte 0x17", {56'd0, u_dut.u_ram.mem[23]}, 64'h11);
        xact(1'b0, 64'h10, 64'h0, 0, 1'b1, rd, er, lat);
        check("load 0x10 data", rd, 64'h1122334455667788);
        check("load 0x10 err", {63'd0, er}, 64'd0);
        check("load latency T+", 64'(lat + 1), 64'd9);

        // Last legal quadword and one past it.
        xact(1'b1, 64'h3F8, 64'hA5A5A5A5A5A5A5A5, 0, 1'b1, rd, er, lat);
        xact(1'b0, 64'h3F8, 64'h0, 0, 1'b0, rd, er, lat);
        check("load 0x3F8 data", rd, 64'hA5A5A5A5A5A5A5A5);
        check("load 0x3F8 err", {63'd0, er}, 64'd0);
        xact(1'b0, 64'h3F9, 64'h0, 0, 1'b0, rd, er, lat);
        check("load 0x3F9 err", {63'd0, er}, 64'd1);
        check("load 0x3F9 rdata", rd, 64'd0);
        check("error latency T+", 64'(lat + 1), 64'd1);

        // Address near 2^64 must not wrap; store at 2^63 must not touch RAM.
        xact(1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 0, 1'b0, rd, er, lat);
        check("wrap load err", {63'd0, er}, 64'd1);
        xact(1'b1, 64'h8000000000000000, 64'hDEADDEADDEADDEAD, 0, 1'b1, rd, er, lat);
        check("2^63 store err", {63'd0, er}, 64'd1);
        for (int i = 0; i < 4; i++)
            check("ram low bytes", {56'd0, u_dut.u_ram.mem[i]}, 64'(i));

        // Response held under backpressure for 5 cycles.
        xact(1'b0, 64'h10, 64'h0, 5, 1'b0, rd, er, lat);
        check("held load data", rd, 64'h1122334455667788);

        // Reset during the fourth byte of a store.
        xact(1'b1, 64'h40, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0, rd, er, lat);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40; req_wdata = 64'h0102030405060708;
        @(posedge clk); #1;
        req_valid = 1'b0;
        busy = 1'b1; pending = 1'b1; exp_first = cycle + 100;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        busy = 1'b0; pending = 1'b0;
        for (int i = 0; i < 3; i++) mm[64 + i] = 8'(8 - i);
        #1;
        check("mid-reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("mid-reset req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xact(1'b0, 64'h40, 64'h0, 0, 1'b0, rd, er, lat);
        check("post-reset load", rd, 64'hFFFFFFFFFF060708);

        // Unaligned store.
        xact(1'b1, 64'h13, 64'hCAFEF00DDEADBEEF, 0, 1'b0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        check("unaligned store err", {63'd0, er}, 64'd1);
        check("unaligned ram byte", {56'd0, u_dut.u_ram.mem[19]}, 64'h55);
`else
        check("unaligned store err", {63'd0, er}, 64'd0);
        xact(1'b0, 64'h13, 64'h0, 0, 1'b0, rd, er, lat);
        check("unaligned load data", rd, 64'hCAFEF00DDEADBEEF);
`endif
        xact(1'b0, 64'h10, 64'h0, 0, 1'b1, rd, er, lat);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout at cycle %0d", cycle);
        $fatal(1, "timeout");
    end

endmodule
